// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with a small TX FIFO
//
// Ports:
//   clk             system clock, all state updates on the rising edge
//   rst             asynchronous active-high reset
//   address         CPU data address; window chosen by MMIO_BASE_UART / MMIO_MASK_UART
//   write_data      CPU write data
//   write_data_sig  CPU write strobe
//   read_data       register read data, combinational, 0 when not selected
//   selected        address hits this register window, combinational
//   out             serial TX line, idle high
//   irq             level interrupt: irq_en & FIFO empty & serializer idle
//
// Registers (index = address[3:2]):
//   0 TXDATA  W    push write_data[7:0]; reads 0
//   1 STATUS  R/W1C  {count[8:4], overflow[3], busy[2], empty[1], full[0]}
//   2 DIV     R/W  bit period in clk cycles; 0 is stored as 1
//   3 CTRL    R/W  bit0 irq_en
module mmio_uart_tx #(
    parameter logic [31:0] MMIO_BASE_UART = 32'hA000_0000,
    parameter logic [31:0] MMIO_MASK_UART = 32'hFFFF_FFF0,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [15:0] DEFAULT_DIV    = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_data_sig,
    output logic [31:0] read_data,
    output logic        selected,
    output logic        out,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Register state
    state_t         r_state;
    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic [15:0]    r_div;
    logic           r_irq_en;
    logic [7:0]     r_shift;
    logic [2:0]     r_bit_idx;
    logic [15:0]    r_baud;
    logic [15:0]    r_period;

    // Combinational signals
    state_t         w_state_nx;
    logic [1:0]     w_reg_idx;
    logic           w_wr;
    logic           w_push;
    logic           w_push_ok;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic           w_busy;
    logic           w_baud_end;
    logic [4:0]     w_count_field;
    logic [15:0]    w_div_wr;
    logic           w_unused_wdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign selected  = ((address & MMIO_MASK_UART) == MMIO_BASE_UART);
    assign w_reg_idx = address[3:2];
    assign w_wr      = selected & write_data_sig;
    assign w_push    = w_wr && (w_reg_idx == 2'd0);

    assign w_full        = (r_count == FULL_COUNT);
    assign w_empty       = (r_count == '0);
    assign w_busy        = (r_state != S_IDLE);
    assign w_baud_end    = (r_baud == (r_period - 16'd1));
    assign w_count_field = 5'(r_count);
    assign w_div_wr      = (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = w_push & (~w_full | w_pop);

    assign w_unused_wdata = ^write_data[31:16];

    // ------------------------------------------------------------------
    // Serializer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Serializer FSM: next state and pop request
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end && (r_bit_idx == 3'd7)) begin
                    w_state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    // Chain straight into the next frame so back-to-back bytes have no idle gap.
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_state_nx = S_START;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serializer datapath: shift register, bit index, baud counter, period
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= 8'd0;
            r_bit_idx <= 3'd0;
            r_baud    <= 16'd0;
            r_period  <= DEFAULT_DIV;
        end else if (w_pop) begin
            // The divisor is sampled once per frame so DIV writes never stretch a frame in flight.
            r_shift   <= r_mem[r_rd_ptr];
            r_period  <= r_div;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
        end else if (r_state != S_IDLE) begin
            if (w_baud_end) begin
                r_baud <= 16'd0;
                if (r_state == S_DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

    // Line driven straight from state so a reset returns it high immediately.
    always_comb begin
        out = 1'b1;
        case (r_state)
            S_START: out = 1'b0;
            S_DATA:  out = r_shift[0];
            default: out = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_div      <= DEFAULT_DIV;
            r_irq_en   <= 1'b0;
        end else begin
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end else if (w_wr && (w_reg_idx == 2'd1) && write_data[3]) begin
                r_overflow <= 1'b0;
            end
            if (w_wr && (w_reg_idx == 2'd2)) begin
                r_div <= w_div_wr;
            end
            if (w_wr && (w_reg_idx == 2'd3)) begin
                r_irq_en <= write_data[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        read_data = 32'd0;
        if (selected) begin
            case (w_reg_idx)
                2'd1:    read_data = {23'd0, w_count_field, r_overflow, w_busy, w_empty, w_full};
                2'd2:    read_data = {16'd0, r_div};
                2'd3:    read_data = {31'd0, r_irq_en};
                default: read_data = 32'd0;
            endcase
        end
    end

    assign irq = r_irq_en & w_empty & (r_state == S_IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'hA000_0000;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_ST   = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
    localparam logic [31:0] A_CTRL = BASE + 32'hC;
    localparam int          DEPTH  = 4;
    localparam int          LOG_N  = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        write_data_sig = 1'b0;
    logic [31:0] read_data;
    logic        selected;
    logic        out;
    logic        irq;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic line_log [0:LOG_N-1];
    logic busy_log [0:LOG_N-1];
    logic irq_log  [0:LOG_N-1];

    logic [7:0] exp_bytes [$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_sel;
        logic [31:0] exp_rd;
        string       nm;
    } vec_t;

    vec_t vecs [$];

    mmio_uart_tx dut (
        .clk            (clk),
        .rst            (rst),
        .address        (address),
        .write_data     (write_data),
        .write_data_sig (write_data_sig),
        .read_data      (read_data),
        .selected       (selected),
        .out            (out),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // cyc == number of rising edges so far; outputs logged on the falling edge.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            line_log[cyc] = out;
            busy_log[cyc] = read_data[2];
            irq_log[cyc]  = irq;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d, limit reached", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic es, input logic [31:0] er, input string nm);
        vec_t v;
        v.we = we; v.addr = a; v.data = d; v.exp_sel = es; v.exp_rd = er; v.nm = nm;
        vecs.push_back(v);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; write_data = d; write_data_sig = 1'b1;
        @(negedge clk);
        write_data_sig = 1'b0; address = A_ST;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
        @(negedge clk);
        write_data_sig = 1'b0; address = a;
        #1;
        d = read_data;
        s = selected;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // k TXDATA writes on consecutive edges; n0 is the edge of the first write.
    task automatic burst(input int k, input logic [1:0] lo, output int n0);
        n0 = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (i == 0) n0 = cyc + 1;
            address        = A_TX | {30'd0, lo};
            write_data     = {24'($urandom), exp_bytes[i]};
            write_data_sig = 1'b1;
        end
        @(negedge clk);
        write_data_sig = 1'b0;
        address        = A_ST;
    endtask

    // 8N1 bit at position i of a frame: start, 8 data LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic check_frames(input string nm, input int start, input int dv,
                                input int j0, input int nb, input logic idle_after);
        int bad;
        int fl;
        int idx;
        bad = 0;
        fl  = 10 * dv;
        for (int j = 0; j < nb; j++) begin
            for (int t = 0; t < fl; t++) begin
                idx = start + j * fl + t;
                if (idx >= LOG_N || line_log[idx] !== frame_bit(exp_bytes[j0 + j], t / dv)) bad++;
            end
        end
        if (idle_after) begin
            idx = start + nb * fl;
            if (idx >= LOG_N || line_log[idx] !== 1'b1) bad++;
        end
        chk(nm, 32'(bad), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic        s;
        int          n0;
        int          dv;
        int          k;
        int          acc;
        int          bad;
        int          rel;

        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out", 32'(out), 32'd1);
        chk("post_rst_irq", 32'(irq), 32'd0);
        rd(A_ST, d, s);   chk("rst_status", d, 32'h2);
        rd(A_DIV, d, s);  chk("rst_div", d, 32'd868);
        rd(A_CTRL, d, s); chk("rst_ctrl", d, 32'd0);

        // ---------------- register/decode table ----------------
        addv(1'b0, A_ST,              32'h0,         1'b1, 32'h2, "tbl_status");
        addv(1'b1, A_DIV,             32'h0,         1'b1, 32'h0, "");
        addv(1'b0, A_DIV,             32'h0,         1'b1, 32'h1, "tbl_div0_is_1");
        addv(1'b1, A_DIV,             32'hDEAD_0007, 1'b1, 32'h0, "");
        addv(1'b0, A_DIV,             32'h0,         1'b1, 32'h7, "tbl_div_upper");
        addv(1'b1, A_CTRL,            32'hFFFF_FFFE, 1'b1, 32'h0, "");
        addv(1'b0, A_CTRL,            32'h0,         1'b1, 32'h0, "tbl_ctrl_bit0_only");
        addv(1'b1, A_CTRL,            32'h3,         1'b1, 32'h0, "");
        addv(1'b0, A_CTRL,            32'h0,         1'b1, 32'h1, "tbl_ctrl_en");
        addv(1'b1, A_CTRL,            32'h0,         1'b1, 32'h0, "");
        addv(1'b0, A_TX,              32'h0,         1'b1, 32'h0, "tbl_txdata_reads0");
        addv(1'b0, BASE + 32'h10,     32'h0,         1'b0, 32'h0, "tbl_base_plus10");
        addv(1'b1, BASE + 32'h18,     32'h9,         1'b0, 32'h0, "");
        addv(1'b0, A_DIV,             32'h0,         1'b1, 32'h7, "tbl_alias_div_nowrite");
        addv(1'b1, BASE + 32'h10,     32'h55,        1'b0, 32'h0, "");
        addv(1'b0, A_ST,              32'h0,         1'b1, 32'h2, "tbl_alias_tx_nopush");
        addv(1'b0, 32'h2000_0004,     32'h0,         1'b0, 32'h0, "tbl_far_addr");
        addv(1'b1, A_ST,              32'hFFFF_FFFF, 1'b1, 32'h0, "");
        addv(1'b0, A_ST,              32'h0,         1'b1, 32'h2, "tbl_status_ro");
        addv(1'b0, BASE + 32'h7,      32'h0,         1'b1, 32'h2, "tbl_status_lowbits");

        foreach (vecs[i]) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].data);
            end else begin
                rd(vecs[i].addr, d, s);
                chk({vecs[i].nm, "_sel"}, 32'(s), 32'(vecs[i].exp_sel));
                chk(vecs[i].nm, d, vecs[i].exp_rd);
            end
        end

        // ---------------- single frame, DIV=4, 0xA5 ----------------
        wr(A_DIV, 32'd4);
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        burst(1, 2'd0, n0);
        wait_until(n0 + 44);
        check_frames("single_a5_line", n0 + 1, 4, 0, 1, 1'b1);
        chk("single_pre_pop_high", 32'(line_log[n0]), 32'd1);
        bad = 0;
        for (int t = 1; t <= 40; t++) if (busy_log[n0 + t] !== 1'b1) bad++;
        chk("single_busy_frame", 32'(bad), 32'd0);
        chk("single_busy_after", 32'(busy_log[n0 + 41]), 32'd0);

        // ---------------- back-to-back with overflow ----------------
        exp_bytes.delete();
        for (int i = 1; i <= 6; i++) exp_bytes.push_back(8'(i));
        burst(6, 2'd0, n0);
        rd(A_ST, d, s);
        chk("b2b_status_full_ovf", d, 32'h4D);
        wait_until(n0 + 1 + 200 + 2);
        check_frames("b2b_five_frames", n0 + 1, 4, 0, 5, 1'b1);
        rd(A_ST, d, s);
        chk("b2b_status_after", d, 32'h0A);
        wr(A_ST, 32'h8);
        rd(A_ST, d, s);
        chk("b2b_ovf_cleared", d, 32'h02);

        // ---------------- DIV change mid-frame ----------------
        exp_bytes.delete();
        exp_bytes.push_back(8'h96);
        exp_bytes.push_back(8'h4B);
        burst(2, 2'd0, n0);
        wr(A_DIV, 32'd2);
        wait_until(n0 + 1 + 40 + 20 + 2);
        check_frames("divchg_frame1", n0 + 1, 4, 0, 1, 1'b0);
        check_frames("divchg_frame2", n0 + 41, 2, 1, 1, 1'b1);

        // ---------------- randomized bursts vs frame model ----------------
        for (int it = 0; it < 12; it++) begin
            dv = $urandom_range(1, 5);
            k  = $urandom_range(1, 7);
            exp_bytes.delete();
            for (int i = 0; i < k; i++) exp_bytes.push_back(8'($urandom));
            wr(A_DIV, 32'(dv));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            burst(k, 2'($urandom_range(0, 3)), n0);
            // The first byte leaves the FIFO one edge after it arrives, so one more than DEPTH fits.
            acc = (k > DEPTH + 1) ? DEPTH + 1 : k;
            wait_until(n0 + 1 + acc * 10 * dv + 2);
            check_frames($sformatf("rand%0d_line_k%0d_div%0d", it, k, dv), n0 + 1, dv, 0, acc, 1'b1);
            rd(A_ST, d, s);
            chk($sformatf("rand%0d_status", it), d, (k > DEPTH + 1) ? 32'h0A : 32'h02);
            if (k > DEPTH + 1) wr(A_ST, 32'h8);
        end

        // ---------------- reset mid-frame ----------------
        wr(A_DIV, 32'd4);
        exp_bytes.delete();
        exp_bytes.push_back(8'h37);
        burst(1, 2'd0, n0);
        wait_until(n0 + 18);
        #1;
        chk("midrst_bit3_low", 32'(out), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_out_async", 32'(out), 32'd1);
        chk("midrst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        rd(A_ST, d, s);
        chk("midrst_status", d, 32'h2);
        rd(A_DIV, d, s);
        chk("midrst_div", d, 32'd868);
        wait_until(rel + 60);
        bad = 0;
        for (int t = 1; t < 58; t++) if (line_log[rel + t] !== 1'b1) bad++;
        chk("midrst_line_idle", 32'(bad), 32'd0);

        // ---------------- interrupt ----------------
        wr(A_DIV, 32'd4);
        wr(A_CTRL, 32'h1);
        @(negedge clk);
        #1;
        chk("irq_idle_en", 32'(irq), 32'd1);
        exp_bytes.delete();
        exp_bytes.push_back(8'h3C);
        burst(1, 2'd0, n0);
        wait_until(n0 + 44);
        chk("irq_before_write", 32'(irq_log[n0 - 1]), 32'd1);
        bad = 0;
        for (int t = 0; t <= 40; t++) if (irq_log[n0 + t] !== 1'b0) bad++;
        chk("irq_low_during_frame", 32'(bad), 32'd0);
        chk("irq_after_stop", 32'(irq_log[n0 + 41]), 32'd1);
        check_frames("irq_frame_line", n0 + 1, 4, 0, 1, 1'b1);
        wr(A_CTRL, 32'h0);
        #1;
        chk("irq_disabled", 32'(irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
